// File: rtl/router_fsm.sv
// Packet sequencing controller for the 1x3 router: decodes the header address,
// steps through header/payload/parity loading and recovers from full or soft-reset FIFOs.
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     state, next_state;
  logic [1:0] addr;
  logic       hdr_empty;
  logic       addr_empty;
  logic       soft_hit;

  // Empty flag of the port named on the bus (header decode) and of the latched port.
  always_comb begin
    hdr_empty  = 1'b0;
    addr_empty = 1'b0;
    soft_hit   = 1'b0;
    case (data_in)
      2'd0:    hdr_empty = fifo_empty_0;
      2'd1:    hdr_empty = fifo_empty_1;
      2'd2:    hdr_empty = fifo_empty_2;
      default: hdr_empty = 1'b0;
    endcase
    case (addr)
      2'd0:    begin addr_empty = fifo_empty_0; soft_hit = soft_reset_0; end
      2'd1:    begin addr_empty = fifo_empty_1; soft_hit = soft_reset_1; end
      2'd2:    begin addr_empty = fifo_empty_2; soft_hit = soft_reset_2; end
      default: begin addr_empty = 1'b0;         soft_hit = 1'b0;         end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= DECODE_ADDRESS;
      addr  <= 2'd0;
    end else begin
      state <= next_state;
      if (state == DECODE_ADDRESS && pkt_valid) addr <= data_in;
    end
  end

  always_comb begin
    next_state = state;
    if (soft_hit) begin
      next_state = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (pkt_valid && data_in != 2'd3)
            next_state = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
        LOAD_FIRST_DATA: next_state = LOAD_DATA;
        LOAD_DATA: begin
          // Full wins over a falling pkt_valid; low_packet_valid carries the parity path later.
          if (fifo_full)       next_state = FIFO_FULL_STATE;
          else if (!pkt_valid) next_state = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) next_state = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)           next_state = DECODE_ADDRESS;
          else if (low_packet_valid) next_state = LOAD_PARITY;
          else                       next_state = LOAD_DATA;
        end
        LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY: begin
          if (addr_empty) next_state = LOAD_FIRST_DATA;
        end
        default: next_state = DECODE_ADDRESS;
      endcase
    end
  end

  always_comb begin
    detect_add    = (state == DECODE_ADDRESS);
    lfd_state     = (state == LOAD_FIRST_DATA);
    ld_state      = (state == LOAD_DATA);
    laf_state     = (state == LOAD_AFTER_FULL);
    full_state    = (state == FIFO_FULL_STATE);
    rst_int_reg   = (state == CHECK_PARITY_ERROR);
    write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                    (state == LOAD_AFTER_FULL);
    busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);
    state_dbg     = state;
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: a vector table of {inputs, expected Moore outputs}
// plus hand-written multi-cycle sequences (long payload, stall, async reset).
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid, parity_done, low_packet_valid, fifo_full;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;
  logic [2:0] state_dbg;

  always #5 clock = ~clock;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_packet_valid(low_packet_valid), .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy), .state_dbg(state_dbg)
  );

  // Output vector order: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
  localparam logic [7:0] O_DA  = 8'b1000_0000;
  localparam logic [7:0] O_LFD = 8'b0100_0001;
  localparam logic [7:0] O_LD  = 8'b0010_0100;
  localparam logic [7:0] O_LAF = 8'b0001_0101;
  localparam logic [7:0] O_FUL = 8'b0000_1001;
  localparam logic [7:0] O_LP  = 8'b0000_0101;
  localparam logic [7:0] O_CPE = 8'b0000_0011;
  localparam logic [7:0] O_WTE = 8'b0000_0001;

  typedef struct packed {
    logic       pv;
    logic [1:0] d;
    logic       pd;
    logic       lpv;
    logic       full;
    logic [2:0] empty;
    logic [2:0] sr;
    logic [7:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];

  function automatic logic [7:0] outs();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            write_enb_reg, rst_int_reg, busy};
  endfunction

  function automatic vec_t mk(logic pv, logic [1:0] d, logic pd, logic lpv, logic full,
                              logic [2:0] empty, logic [2:0] sr, logic [7:0] exp);
    vec_t v;
    v.pv = pv; v.d = d; v.pd = pd; v.lpv = lpv; v.full = full;
    v.empty = empty; v.sr = sr; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    pkt_valid = v.pv; data_in = v.d; parity_done = v.pd; low_packet_valid = v.lpv;
    fifo_full = v.full;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = v.empty;
    {soft_reset_2, soft_reset_1, soft_reset_0} = v.sr;
  endtask

  // Drive at the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input vec_t v);
    @(negedge clock);
    drive(v);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    drive(mk(0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_DA));
    resetn = 1'b0;
    #1;
    check("reset_asserted", outs(), O_DA);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    check("reset_released", outs(), O_DA);
  endtask

  initial begin
    resetn = 1'b1;
    drive(mk(0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_DA));

    //             pv  d    pd lpv full empty    sr       expected-after-edge
    tbl.push_back(mk(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LFD)); // header to port 1
    tbl.push_back(mk(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LD));
    tbl.push_back(mk(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LD));
    tbl.push_back(mk(0, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LP));
    tbl.push_back(mk(0, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_CPE));
    tbl.push_back(mk(0, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_DA));
    tbl.push_back(mk(1, 2'd3, 0, 0, 0, 3'b111, 3'b000, O_DA));  // invalid address
    tbl.push_back(mk(0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_DA));  // no pkt_valid
    tbl.push_back(mk(1, 2'd2, 0, 0, 0, 3'b011, 3'b000, O_WTE)); // port 2 not empty
    tbl.push_back(mk(0, 2'd0, 0, 0, 0, 3'b011, 3'b000, O_WTE)); // latched addr used
    tbl.push_back(mk(0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LFD));
    tbl.push_back(mk(1, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LD));
    tbl.push_back(mk(0, 2'd0, 0, 0, 1, 3'b111, 3'b000, O_FUL)); // full + pv fall together
    tbl.push_back(mk(0, 2'd0, 0, 0, 1, 3'b111, 3'b000, O_FUL));
    tbl.push_back(mk(0, 2'd0, 0, 1, 0, 3'b111, 3'b000, O_LAF));
    tbl.push_back(mk(0, 2'd0, 0, 1, 0, 3'b111, 3'b000, O_LP));
    tbl.push_back(mk(0, 2'd0, 0, 0, 1, 3'b111, 3'b000, O_CPE));
    tbl.push_back(mk(0, 2'd0, 0, 0, 1, 3'b111, 3'b000, O_FUL)); // full during parity check
    tbl.push_back(mk(0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LAF));
    tbl.push_back(mk(0, 2'd0, 1, 1, 0, 3'b111, 3'b000, O_DA));  // parity_done wins
    tbl.push_back(mk(1, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LFD)); // header to port 0
    tbl.push_back(mk(1, 2'd0, 0, 0, 0, 3'b111, 3'b010, O_LD));  // other port soft reset
    tbl.push_back(mk(1, 2'd0, 0, 0, 0, 3'b111, 3'b010, O_LD));
    tbl.push_back(mk(1, 2'd0, 0, 0, 0, 3'b111, 3'b001, O_DA));  // own soft reset
    tbl.push_back(mk(1, 2'd0, 0, 0, 0, 3'b110, 3'b000, O_WTE));
    tbl.push_back(mk(0, 2'd0, 0, 0, 0, 3'b110, 3'b001, O_DA));  // soft reset from wait
    tbl.push_back(mk(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LFD));
    tbl.push_back(mk(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LD));
    tbl.push_back(mk(1, 2'd1, 0, 0, 1, 3'b111, 3'b000, O_FUL));
    tbl.push_back(mk(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LAF));
    tbl.push_back(mk(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LD));  // resume payload
    tbl.push_back(mk(0, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LP));
    tbl.push_back(mk(0, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_CPE));
    tbl.push_back(mk(0, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_DA));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // 14-byte payload: lfd for exactly one cycle, rst_int for exactly one cycle.
    begin
      int lfd_cnt = 0;
      int rst_cnt = 0;
      step(mk(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LFD));
      check("long_hdr", outs(), O_LFD);
      lfd_cnt += lfd_state;
      for (int i = 0; i < 14; i++) begin
        step(mk(1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LD));
        check($sformatf("long_pay%0d", i), outs(), O_LD);
        lfd_cnt += lfd_state;
      end
      step(mk(0, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LP));
      check("long_lp", outs(), O_LP);
      rst_cnt += rst_int_reg;
      step(mk(0, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_CPE));
      rst_cnt += rst_int_reg;
      step(mk(0, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_DA));
      rst_cnt += rst_int_reg;
      check("long_done", outs(), O_DA);
      check("lfd_cycles", 8'(lfd_cnt), 8'd1);
      check("rst_int_cycles", 8'(rst_cnt), 8'd1);
    end

    // Five-cycle stall, then low_packet_valid resumes the parity path.
    begin
      int full_cnt = 0;
      step(mk(1, 2'd2, 0, 0, 0, 3'b111, 3'b000, O_LFD));
      step(mk(1, 2'd2, 0, 0, 0, 3'b111, 3'b000, O_LD));
      check("stall_ld", outs(), O_LD);
      for (int i = 0; i < 5; i++) begin
        step(mk(1, 2'd2, 0, 0, 1, 3'b111, 3'b000, O_FUL));
        check($sformatf("stall%0d", i), outs(), O_FUL);
        full_cnt += full_state;
      end
      step(mk(0, 2'd2, 0, 1, 0, 3'b111, 3'b000, O_LAF));
      full_cnt += full_state;
      check("stall_laf", outs(), O_LAF);
      check("full_cycles", 8'(full_cnt), 8'd5);
      step(mk(0, 2'd2, 0, 1, 0, 3'b111, 3'b000, O_LP));
      check("stall_lp", outs(), O_LP);
    end

    // Asynchronous reset while stalled: outputs settle before any clock edge.
    step(mk(0, 2'd2, 0, 0, 1, 3'b111, 3'b000, O_CPE));
    step(mk(0, 2'd2, 0, 0, 1, 3'b111, 3'b000, O_FUL));
    check("pre_async_full", outs(), O_FUL);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_outs", outs(), O_DA);
    @(negedge clock);
    resetn = 1'b1;
    drive(mk(0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_DA));
    @(posedge clock);
    #1;
    check("after_async_reset", outs(), O_DA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
